// File: rtl/lc3b_mem_responder.sv
// LC-3b word memory responder: accepts one read/write request at a time,
// stalls it for LATENCY cycles, then pulses mem_resp for one cycle.
module lc3b_mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 accept_c;
  logic                 commit_c;
  logic                 op_wr_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0]          wdata_q;
  logic [1:0]           be_q;

  logic                 cur_wr_c;
  logic [ADDR_BITS-1:0] cur_idx_c;
  logic [15:0]          cur_wdata_c;
  logic [1:0]           cur_be_c;

  logic [15:0]          mem_array [DEPTH];

  // Next-state logic; abort takes priority over the counter reaching the end
  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    accept_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept_c   = 1'b1;
          cnt_nxt    = CNT_W'(LATENCY - 1);
          next_state = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (op_wr_q ? !mem_write : !mem_read) begin
          next_state = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          next_state = RESP;
        end
      end
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY==1 the commit happens on the accepting edge, so use live inputs
  always_comb begin
    commit_c    = (next_state == RESP);
    cur_wr_c    = op_wr_q;
    cur_idx_c   = idx_q;
    cur_wdata_c = wdata_q;
    cur_be_c    = be_q;
    if (state == IDLE) begin
      cur_wr_c    = mem_write;
      cur_idx_c   = mem_address[ADDR_BITS:1];
      cur_wdata_c = mem_wdata;
      cur_be_c    = mem_byte_enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_nxt;
      mem_resp <= commit_c;
      if (accept_c) begin
        op_wr_q <= mem_write;
        idx_q   <= mem_address[ADDR_BITS:1];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
      end
      if (commit_c && !cur_wr_c) begin
        mem_rdata <= mem_array[cur_idx_c];
      end
      if (mem_read && mem_write) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Array is not reset; a write in flight when rst rises is dropped
  always_ff @(posedge clk) begin
    if (commit_c && cur_wr_c && !rst) begin
      if (cur_be_c[0]) mem_array[cur_idx_c][7:0]  <= cur_wdata_c[7:0];
      if (cur_be_c[1]) mem_array[cur_idx_c][15:8] <= cur_wdata_c[15:8];
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder with default parameters
// (ADDR_BITS=8, LATENCY=3).
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .proto_err       (proto_err)
  );

  // Issue one request (called #1 after an edge), wait for mem_resp.
  // lat = edges from drive to resp (-1 on timeout); resp_after = mem_resp one cycle later.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           output int lat, output logic [15:0] rdata,
                           output logic resp_after);
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        lat = i;
        break;
      end
    end
    rdata     = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    resp_after = mem_resp;
  endtask

  task automatic test_reset();
    n_total++;
    if (mem_resp !== 1'b0) $display("FAIL reset_resp: got %b want 0", mem_resp);
    else n_pass++;
    n_total++;
    if (mem_rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", mem_rdata);
    else n_pass++;
    n_total++;
    if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", proto_err);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd; logic ra;
    do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, rd, ra);
    n_total++;
    if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat);
    else n_pass++;
    n_total++;
    if (ra !== 1'b0) $display("FAIL wr_resp_width: got %b want 0", ra);
    else n_pass++;
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, ra);
    n_total++;
    if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat);
    else n_pass++;
    n_total++;
    if (rd !== 16'hBEEF) $display("FAIL rd_data: got %h want beef", rd);
    else n_pass++;
  endtask

  task automatic test_byte_mask();
    int lat; logic [15:0] rd; logic ra;
    logic [15:0] wd [3]  = '{16'h1234, 16'hAA00, 16'hFFFF};
    logic [1:0]  be [3]  = '{2'b01, 2'b10, 2'b00};
    logic [15:0] exp [3] = '{16'hBE34, 16'hAA34, 16'hAA34};
    for (int i = 0; i < 3; i++) begin
      do_access(1'b0, 1'b1, 16'h0010, wd[i], be[i], lat, rd, ra);
      do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, lat, rd, ra);
      n_total++;
      if (rd !== exp[i]) $display("FAIL byte_mask_%0d: got %h want %h", i, rd, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_alias();
    int lat; logic [15:0] rd; logic ra;
    logic [15:0] addrs [2] = '{16'h0211, 16'h0011};
    // Clear rdata first so the alias reads must fetch the word themselves
    do_access(1'b0, 1'b1, 16'h0040, 16'h0000, 2'b11, lat, rd, ra);
    for (int i = 0; i < 2; i++) begin
      do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd, ra);
      do_access(1'b1, 1'b0, addrs[i], 16'h0000, 2'b00, lat, rd, ra);
      n_total++;
      if (rd !== 16'hAA34) $display("FAIL alias_%h: got %h want aa34", addrs[i], rd);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] seen = '0;
    mem_read    = 1'b1;
    mem_address = 16'h0010;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      seen[c-1] = mem_resp;
      if (c == 11) mem_read = 1'b0;
    end
    n_total++;
    if (seen !== 12'b0100_0100_0100) $display("FAIL b2b_pattern: got %b want 010001000100", seen);
    else n_pass++;
    n_total++;
    if (mem_rdata !== 16'hAA34) $display("FAIL b2b_rdata: got %h want aa34", mem_rdata);
    else n_pass++;
  endtask

  task automatic test_abort_reset();
    int lat; logic [15:0] rd; logic ra;
    int resp_cnt;
    do_access(1'b0, 1'b1, 16'h0020, 16'h1111, 2'b11, lat, rd, ra);
    // Read accepted, then dropped one cycle later
    mem_read = 1'b1; mem_address = 16'h0010;
    @(posedge clk); #1;
    mem_read = 1'b0;
    resp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (mem_resp) resp_cnt++;
    end
    n_total++;
    if (resp_cnt !== 0) $display("FAIL abort_no_resp: got %0d pulses want 0", resp_cnt);
    else n_pass++;
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd, ra);
    n_total++;
    if (lat !== 3 || rd !== 16'h1111)
      $display("FAIL after_abort_read: got lat %0d data %h want 3 1111", lat, rd);
    else n_pass++;
    // Write to 0x0020 interrupted by reset in its third cycle
    mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = 16'h2222; mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    #1;
    n_total++;
    if (mem_resp !== 1'b0 || mem_rdata !== 16'h0000)
      $display("FAIL rst_mid_op: got resp %b rdata %h want 0 0000", mem_resp, mem_rdata);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (mem_resp) resp_cnt++;
    end
    n_total++;
    if (resp_cnt !== 0) $display("FAIL rst_no_resp: got %0d pulses want 0", resp_cnt);
    else n_pass++;
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, lat, rd, ra);
    n_total++;
    if (rd !== 16'h1111) $display("FAIL rst_write_discarded: got %h want 1111", rd);
    else n_pass++;
  endtask

  task automatic test_proto_err();
    int lat; logic [15:0] rd; logic ra;
    do_access(1'b1, 1'b1, 16'h0030, 16'h5A5A, 2'b11, lat, rd, ra);
    n_total++;
    if (lat !== 3) $display("FAIL proto_latency: got %0d want 3", lat);
    else n_pass++;
    n_total++;
    if (proto_err !== 1'b1) $display("FAIL proto_err_set: got %b want 1", proto_err);
    else n_pass++;
    do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, lat, rd, ra);
    n_total++;
    if (rd !== 16'h5A5A) $display("FAIL proto_write_data: got %h want 5a5a", rd);
    else n_pass++;
    n_total++;
    if (proto_err !== 1'b1) $display("FAIL proto_err_sticky: got %b want 1", proto_err);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (proto_err !== 1'b0) $display("FAIL proto_err_clear: got %b want 0", proto_err);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 2'b00; mem_address = '0; mem_wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_alias();
    test_back_to_back();
    test_abort_reset();
    test_proto_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
Memory-side responder for the LC-3b word memory interface that the CPU top level drives as initiator. It accepts single-word read and write requests, stalls them for a programmable latency, and then returns a one-cycle mem_resp. Byte-masked writes go into an internal word array. It serves as the synthesizable and simulation memory behind the CPU, and as the reference responder for CPU-level benches.

Parameters:
ADDR_BITS, 8, number of word-address bits; the array holds 2**ADDR_BITS 16-bit words.
LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_read  input  1  read request; initiator holds it until mem_resp
mem_write  input  1  write request; initiator holds it until mem_resp
mem_byte_enable  input  2  write byte mask; bit0 = [7:0], bit1 = [15:8]
mem_address  input  16  byte address; bit0 ignored (word access)
mem_wdata  input  16  write data
mem_resp  output  1  one-cycle completion pulse
mem_rdata  output  16  read data; valid in the mem_resp cycle of a read
proto_err  output  1  sticky flag: mem_read and mem_write were both high in one cycle

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, mem_resp=0, mem_rdata=0x0000, proto_err=0. Array contents are not reset.
- Word index = mem_address[ADDR_BITS:1]. Address bits above ADDR_BITS alias (wrap). Bit0 is ignored.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If mem_read or mem_write is high at a clk edge, the request is accepted.
  - On acceptance, latch op, word index, wdata and byte_enable. Load counter=LATENCY-1.
  - Go to RESP if LATENCY==1, otherwise go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When counter==1 at the edge, go to RESP.
  - If the latched op's request line (mem_read or mem_write) is low at an edge, the request is aborted: go to IDLE, no resp, no write.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Result: mem_resp is high in cycle N+LATENCY, where N is the acceptance cycle. Inputs changing after acceptance (address/data) are ignored.
  - Read: mem_rdata is registered from the array on the edge entering RESP. It holds that value until the next read response.
  - Write: the array is updated on the edge entering RESP, per byte_enable; byte_enable=00 writes nothing. mem_rdata is unchanged.
  - RESP always goes to IDLE. A request still high in the cycle after RESP is treated as a new request. Back-to-back accesses therefore complete every LATENCY+1 cycles.
- Simultaneous read and write at acceptance:
  - Treat as a write and set proto_err. proto_err also sets if both lines are high in any cycle.
  - proto_err clears only on rst.
- Read-after-write to the same word returns the newly written data (the write commits before any later acceptance).
- Reset mid-operation: return immediately to IDLE with mem_resp=0. A pending write is discarded.
- No combinational path from inputs to outputs.

Test Plan:
1. Write then read, LATENCY=3. Write 0xBEEF to addr 0x0010, be=11, accepted in cycle N -> mem_resp high only in N+3. Then read 0x0010 -> mem_resp in its acceptance+3, mem_rdata=0xBEEF.
2. Byte masking. Over 0xBEEF at 0x0010, write 0x1234 with be=01 -> read gives 0xBE34. Write 0xAA00 with be=10 -> 0xAA34. Write with be=00 -> 0xAA34 unchanged.
3. Aliasing, ADDR_BITS=8. Read 0x0211 and 0x0011 -> both return the word at 0x0010 (0xAA34).
4. Back-to-back. mem_read held continuously across three reads -> mem_resp pulses exactly 4 cycles apart, each exactly 1 cycle wide.
5. Abort and reset.
   - mem_read deasserted at N+1 -> no mem_resp; the next read completes normally.
   - rst asserted at N+2 of a write to 0x0020 -> mem_resp stays 0, old word at 0x0020 retained, mem_rdata=0.
6. Protocol error. mem_read=mem_write=1 with wdata=0x5A5A at 0x0030, be=11 -> proto_err=1 and stays 1. Later read of 0x0030 returns 0x5A5A. proto_err clears only on rst.
